// File: rtl/ram_sr_pkg.sv
// Shared types and helpers for the RAM shift-register feeder.
package ram_sr_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_ROW_WAIT,
    S_ROW_SHIFT,
    S_DONE
  } feeder_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_sr_pos_counter.sv
// Column/row position counters for the feeder; both wrap at the image edge.
module ram_sr_pos_counter
  import ram_sr_pkg::*;
#(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          stall,
  input  logic                          col_inc,
  input  logic                          row_inc,
  output logic [cnt_w(IMG_WIDTH)-1:0]   col_idx,
  output logic [cnt_w(IMG_HEIGHT)-1:0]  row_idx,
  output logic                          col_last
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic row_last;

  assign col_last = (col_idx == COL_MAX);
  assign row_last = (row_idx == ROW_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col_idx <= '0;
      row_idx <= '0;
    end else begin
      // The column only moves on an accepted pixel, which a stall already blocks.
      if (col_inc && !stall)
        col_idx <= col_last ? '0 : col_idx + CW'(1);
      if (row_inc)
        row_idx <= row_last ? '0 : row_idx + RW'(1);
    end
  end

endmodule

// File: rtl/ram_sr_feeder.sv
// Upstream controller for the RAM row/column shift register of the conv front end.
// Optional macro RAM_SR_FEEDER_ZERO_PAD_EN inserts ROW_SHIFT-1 zero pixels at each row end.
module ram_sr_feeder
  import ram_sr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 8,
  parameter int ROW_SHIFT  = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          pixel_in,
  input  logic                           pixel_valid,
  output logic                           pixel_ready,
  input  logic [DATA_WIDTH*ROW_SHIFT-1:0] row_data_in,
  input  logic                           row_data_valid,
  output logic                           row_data_ready,
  input  logic                           window_ready,
  output logic                           sr_enable,
  output logic                           sr_shift_row_up,
  output logic [DATA_WIDTH-1:0]          sr_column_shift_in,
  output logic [DATA_WIDTH*ROW_SHIFT-1:0] sr_row_shift_in,
  output logic                           window_valid,
  output logic [cnt_w(IMG_WIDTH)-1:0]    col_idx,
  output logic [cnt_w(IMG_HEIGHT)-1:0]   row_idx,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] WIN_COL = CW'(ROW_SHIFT - 1);
  localparam logic [RW-1:0] WIN_ROW = RW'(ROW_SHIFT - 1);

  feeder_state_t state, state_nxt;
  logic stall, pixel_hs, row_hs, col_last, pad_issue, pad_done;

  assign stall          = window_valid && !window_ready;
  assign pixel_ready    = (state == S_STREAM) && !stall;
  assign pixel_hs       = pixel_valid && pixel_ready;
  assign row_data_ready = (state == S_ROW_WAIT) && pad_done;
  assign row_hs         = row_data_valid && row_data_ready;
  assign busy           = (state != S_IDLE);
  assign frame_done     = (state == S_DONE);

`ifdef RAM_SR_FEEDER_ZERO_PAD_EN
  localparam int PW = cnt_w(ROW_SHIFT);
  localparam logic [PW-1:0] PAD_N = PW'(ROW_SHIFT - 1);
  logic [PW-1:0] pad_cnt;

  assign pad_done  = (pad_cnt == PAD_N);
  assign pad_issue = (state == S_ROW_WAIT) && !pad_done && !stall;

  always_ff @(posedge clock) begin
    if (reset || state != S_ROW_WAIT)
      pad_cnt <= '0;
    else if (pad_issue)
      pad_cnt <= pad_cnt + PW'(1);
  end
`else
  assign pad_done  = 1'b1;
  assign pad_issue = 1'b0;
`endif

  ram_sr_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == S_IDLE),
    .stall   (stall),
    .col_inc (pixel_hs),
    .row_inc (row_hs),
    .col_idx (col_idx),
    .row_idx (row_idx),
    .col_last(col_last)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_STREAM;
      S_STREAM:    if (pixel_hs && col_last) state_nxt = S_ROW_WAIT;
      S_ROW_WAIT:  if (row_hs) state_nxt = S_ROW_SHIFT;
      // The row counter has already wrapped to 0 when the last frame row was shifted.
      S_ROW_SHIFT: state_nxt = (row_idx == '0) ? S_DONE : S_STREAM;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Shift-register drive: registered one cycle after the accepting handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_enable          <= 1'b0;
      sr_shift_row_up    <= 1'b0;
      sr_column_shift_in <= '0;
      sr_row_shift_in    <= '0;
      window_valid       <= 1'b0;
    end else begin
      sr_enable       <= pixel_hs || row_hs || pad_issue;
      sr_shift_row_up <= row_hs;
      if (pixel_hs)
        sr_column_shift_in <= pixel_in;
      else if (pad_issue)
        sr_column_shift_in <= '0;
      if (row_hs)
        sr_row_shift_in <= row_data_in;
      if (pixel_hs)
        window_valid <= (col_idx >= WIN_COL) && (row_idx >= WIN_ROW);
      else if (!stall)
        window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_sr_feeder.sv
// Directed bench for ram_sr_feeder (10x4 image, 3-row kernel, default build).
module tb_ram_sr_feeder;

  logic        clock = 1'b0;
  logic        reset, start, pixel_valid, row_data_valid, window_ready;
  logic [7:0]  pixel_in;
  logic [23:0] row_data_in;
  logic        pixel_ready, row_data_ready, sr_enable, sr_shift_row_up;
  logic [7:0]  sr_column_shift_in;
  logic [23:0] sr_row_shift_in;
  logic        window_valid, busy, frame_done;
  logic [3:0]  col_idx;
  logic [1:0]  row_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ram_sr_feeder #(
    .DATA_WIDTH(8), .IMG_WIDTH(10), .IMG_HEIGHT(4), .ROW_SHIFT(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .row_data_in(row_data_in), .row_data_valid(row_data_valid), .row_data_ready(row_data_ready),
    .window_ready(window_ready), .sr_enable(sr_enable), .sr_shift_row_up(sr_shift_row_up),
    .sr_column_shift_in(sr_column_shift_in), .sr_row_shift_in(sr_row_shift_in),
    .window_valid(window_valid), .col_idx(col_idx), .row_idx(row_idx),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic        start;
    logic        pv;
    logic [7:0]  px;
    logic        rdv;
    logic [23:0] rd;
    logic [44:0] exp;
  } vec_t;

  vec_t tbl [16];

  // Output bundle: {pr, rdr, en, up, wv, busy, fd, col, row, scol, srow}
  function automatic logic [44:0] mk(input logic pr, input logic rdr, input logic en,
                                     input logic up, input logic wv, input logic bs,
                                     input logic fd, input logic [3:0] c, input logic [1:0] r,
                                     input logic [7:0] sc, input logic [23:0] sr);
    return {pr, rdr, en, up, wv, bs, fd, c, r, sc, sr};
  endfunction

  function automatic logic [44:0] outs();
    return {pixel_ready, row_data_ready, sr_enable, sr_shift_row_up, window_valid, busy,
            frame_done, col_idx, row_idx, sr_column_shift_in, sr_row_shift_in};
  endfunction

  task automatic check(input string nm, input logic [44:0] exp);
    logic [44:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push_pixel(input logic [7:0] d);
    bit done;
    done = 0;
    pixel_in = d;
    pixel_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clock);
      if (pixel_ready) done = 1;
      @(posedge clock); #1;
    end
    pixel_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL push_pixel_timeout: pixel_ready got %b required 1", pixel_ready);
    end
  endtask

  task automatic fetch_row(input logic [23:0] d);
    bit done;
    done = 0;
    row_data_in = d;
    row_data_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clock);
      if (row_data_ready) done = 1;
      @(posedge clock); #1;
    end
    row_data_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_row_timeout: row_data_ready got %b required 1", row_data_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    row_data_valid = 1'b0; row_data_in = '0; window_ready = 1'b1;

    // Reset-state check
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); check("reset_state", mk(0,0,0,0,0,0,0,4'd0,2'd0,8'h00,24'h0));
    @(posedge clock); #1;

    // Reset held two cycles in the middle of a row aborts the frame
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
    push_pixel(8'h55); push_pixel(8'h56); push_pixel(8'h57);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); check("mid_stream_reset", mk(0,0,0,0,0,0,0,4'd0,2'd0,8'h00,24'h0));
    @(posedge clock); #1;

    // First row and its row fetch as a per-cycle vector table
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 24'h0, mk(0,0,0,0,0,0,0,4'd0,2'd0,8'h00,24'h0)};
    for (int k = 0; k < 10; k++)
      tbl[1+k] = '{1'b0, 1'b1, 8'(k), 1'b0, 24'h0,
                   mk(1,0,(k > 0),0,0,1,0,4'(k),2'd0,(k > 0) ? 8'(k-1) : 8'h00,24'h0)};
    tbl[11] = '{1'b0, 1'b1, 8'hAA, 1'b0, 24'h0,     mk(0,1,1,0,0,1,0,4'd0,2'd0,8'h09,24'h0)};
    tbl[12] = '{1'b0, 1'b1, 8'hBB, 1'b1, 24'h030405, mk(0,1,0,0,0,1,0,4'd0,2'd0,8'h09,24'h0)};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 24'h030405, mk(0,0,1,1,0,1,0,4'd0,2'd1,8'h09,24'h030405)};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 24'h0,     mk(1,0,0,0,0,1,0,4'd0,2'd1,8'h09,24'h030405)};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 24'h0,     mk(1,0,0,0,0,1,0,4'd0,2'd1,8'h09,24'h030405)};

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; pixel_valid = tbl[i].pv; pixel_in = tbl[i].px;
      row_data_valid = tbl[i].rdv; row_data_in = tbl[i].rd;
      @(negedge clock); check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clock); #1;
    end
    start = 1'b0; pixel_valid = 1'b0; row_data_valid = 1'b0;

    // Row 1
    for (int i = 0; i < 10; i++) push_pixel(8'h10 + 8'(i));
    fetch_row(24'h131415);
    @(negedge clock); check("row1_shift", mk(0,0,1,1,0,1,0,4'd0,2'd2,8'h19,24'h131415));
    @(posedge clock); #1;

    // Row 2: first complete window, then a three-cycle downstream stall
    push_pixel(8'h20); push_pixel(8'h21);
    @(negedge clock); check("row2_col1", mk(1,0,1,0,0,1,0,4'd2,2'd2,8'h21,24'h131415));
    @(posedge clock); #1;
    window_ready = 1'b0;
    push_pixel(8'h22);
    pixel_in = 8'h23; pixel_valid = 1'b1;
    @(negedge clock); check("stall_c1", mk(0,0,1,0,1,1,0,4'd3,2'd2,8'h22,24'h131415));
    @(posedge clock); #1;
    @(negedge clock); check("stall_c2", mk(0,0,0,0,1,1,0,4'd3,2'd2,8'h22,24'h131415));
    @(posedge clock); #1;
    @(negedge clock); check("stall_c3", mk(0,0,0,0,1,1,0,4'd3,2'd2,8'h22,24'h131415));
    @(posedge clock); #1;
    window_ready = 1'b1;
    @(negedge clock); check("stall_release", mk(1,0,0,0,1,1,0,4'd3,2'd2,8'h22,24'h131415));
    @(posedge clock); #1;
    pixel_valid = 1'b0;
    @(negedge clock); check("resume_pixel", mk(1,0,1,0,1,1,0,4'd4,2'd2,8'h23,24'h131415));
    @(posedge clock); #1;
    @(negedge clock); check("window_consumed", mk(1,0,0,0,0,1,0,4'd4,2'd2,8'h23,24'h131415));
    @(posedge clock); #1;
    for (int i = 4; i < 10; i++) push_pixel(8'h20 + 8'(i));
    fetch_row(24'h232425);
    @(negedge clock); check("row2_shift", mk(0,0,1,1,0,1,0,4'd0,2'd3,8'h29,24'h232425));
    @(posedge clock); #1;

    // Row 3 and frame end
    for (int i = 0; i < 10; i++) push_pixel(8'h30 + 8'(i));
    fetch_row(24'h333435);
    @(negedge clock); check("last_row_shift", mk(0,0,1,1,0,1,0,4'd0,2'd0,8'h39,24'h333435));
    @(posedge clock); #1;
    start = 1'b1;
    @(negedge clock); check("frame_done", mk(0,0,0,0,0,1,1,4'd0,2'd0,8'h39,24'h333435));
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock); check("idle_after_done", mk(0,0,0,0,0,0,0,4'd0,2'd0,8'h39,24'h333435));
    @(posedge clock); #1;
    @(negedge clock); check("start_in_done_ignored", mk(0,0,0,0,0,0,0,4'd0,2'd0,8'h39,24'h333435));
    @(posedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
